gcd_driver: RTL
===============

Name: gcd_driver

Overview:
Initiator side of the GCD engine's start/done handshake. It accepts operand pairs from an upstream valid/ready source and issues each pair to the engine with a single-cycle start pulse. It captures the result on the engine's one-cycle done strobe and queues it, with the measured engine latency, in a result FIFO that drains to a downstream valid/ready sink. Exactly one operation is in flight at any time.

Parameters:
WIDTH, 32, operand and result width; must match the engine.
DEPTH, 4, result FIFO entries; power of two, ≥2.
CYC_W, 16, width of the per-operation cycle counter; the counter saturates.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset; the top level drives the engine's reset_n = ~reset
op_valid  in  1  upstream operand pair valid
op_ready  out  1  driver can accept an operand pair
op_a  in  WIDTH  operand a
op_b  in  WIDTH  operand b
gcd_a  out  WIDTH  to engine a_in
gcd_b  out  WIDTH  to engine b_in
gcd_start  out  1  to engine start; single-cycle pulse
gcd_result  in  WIDTH  from engine result; meaningful only while gcd_done=1
gcd_done  in  1  from engine done; single-cycle strobe
res_valid  out  1  FIFO head valid
res_ready  in  1  downstream accepts FIFO head
res_data  out  WIDTH  GCD at FIFO head
res_cycles  out  CYC_W  engine latency at FIFO head
busy  out  1  an operation is in flight (state ≠ IDLE)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high, named reset. All flops clear on reset.
- Reset values: op_ready=0 while reset is asserted, then per rule below. gcd_start=0, gcd_a=0, gcd_b=0, res_valid=0, res_data=0, res_cycles=0, busy=0. FIFO count=0, read/write pointers=0, state=IDLE.
- All outputs are registered or decoded from registered state. op_ready and res_valid have no combinational path from any input.
- FSM states and transitions:
  - IDLE: op_ready = (fifo_count < DEPTH). On op_valid & op_ready, latch op_a/op_b into gcd_a/gcd_b and go to ISSUE.
  - ISSUE: gcd_start=1 for exactly this cycle; the cycle counter loads 0. Go to WAIT.
  - WAIT: gcd_start=0; the counter increments each cycle and saturates at 2^CYC_W−1. On gcd_done=1, write {gcd_result, counter+1 (saturating)} into the FIFO at this edge and go to IDLE.
- res_cycles semantics: the number of clk edges from the gcd_start cycle to the gcd_done cycle. For operands (48,18) the value is 10.
- gcd_a/gcd_b hold their values from ISSUE through WAIT.
- Accept-to-start latency: a handshake accepted in cycle T gives gcd_start=1 in cycle T+1.
- Done-to-valid latency: the result written on the done cycle D appears as res_valid=1 in cycle D+1.
- Back-to-back: the earliest next op_ready=1 is cycle D+1; its start is at D+2.
- FIFO: res_valid = (count ≠ 0). A pop occurs on res_valid & res_ready. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Overflow cannot occur, because admission requires a free slot and only one operation is in flight. An internal assertion flags a push while full.
- gcd_done seen in IDLE or ISSUE: ignored, with no FIFO write.
- gcd_done is sampled only in WAIT.
- Reset asserted mid-operation (ISSUE or WAIT): immediate return to IDLE, FIFO emptied, any pending result discarded. The engine is reset simultaneously through the top-level tie.
- op_valid while op_ready=0: the operands are not sampled, and the upstream must hold them.

Test Plan:
- Reset, then op (48,18) with res_ready=1 -> gcd_start one cycle after accept, busy=1 until the done cycle, res_valid one cycle after done with res_data=6 and res_cycles=10.
- Edge operands (0,0), then (7,7), then (0,5) -> res_data 0,7,5 with res_cycles 2,4,3, in order.
- res_ready=0; push 5 ops of (12,8) -> the first 4 complete with res_data=4 each; op_ready=0 after the 4th result is stored; the 5th is not accepted until one pop, then it completes normally.
- FIFO holding 2 entries while a new done arrives in the same cycle as res_ready=1 -> count stays 2, and the order of res_data is preserved.
- Reset asserted during WAIT of op (2^32−1, 1) -> next cycle busy=0, res_valid=0, gcd_start=0; after release, op (9,6) returns 3.
- Force gcd_done=1 in IDLE with no op pending -> no FIFO write, res_valid stays 0.

Source files
------------

// File: rtl/gcd_driver.sv
// rtl/gcd_driver.sv - start/done initiator for the GCD engine with a latency-tagged result FIFO
module gcd_driver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_start,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CYC_W-1:0] res_cycles,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_done;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [CYC_W-1:0] cyc_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             push;
  logic             pop;

  assign res_valid  = (count != '0);
  assign res_data   = data_mem[rd_ptr];
  assign res_cycles = cyc_mem[rd_ptr];
  assign busy       = (state != IDLE);

  always_comb begin
    accept     = (state == IDLE) && op_valid && op_ready;
    push       = (state == WAIT) && gcd_done;
    pop        = res_valid && res_ready;
    cyc_done   = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_W'(1);
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_ready  <= 1'b0;
      gcd_start <= 1'b0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      cyc_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        cyc_mem[i]  <= '0;
      end
    end else begin
      // op_ready is precomputed for the next cycle so it never depends on live inputs
      op_ready <= ((state == IDLE && !accept) || push) && (count_next < CNT_W'(DEPTH));
      count    <= count_next;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) begin
        data_mem[wr_ptr] <= gcd_result;
        cyc_mem[wr_ptr]  <= cyc_done;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            gcd_a     <= op_a;
            gcd_b     <= op_b;
            gcd_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          gcd_start <= 1'b0;
          cyc_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cyc_cnt <= cyc_done;
          if (gcd_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && count == CNT_W'(DEPTH)));

endmodule
